pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Consumes the hazard indications (load-use stall request, branch flush, data-memory wait) and turns them into per-stage write enables, flushes and bubble inserts for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Holds a small FSM for multi-cycle data-memory accesses, including a timeout.
- Sits between the hazard detection logic and the pipeline registers in the core top level.

Parameters:
- MEM_TIMEOUT_CYCLES, 200: MEM_WAIT cycles before the pending access is abandoned.
- WAIT_COUNTER_WIDTH, 8: width of the wait counter; must hold MEM_TIMEOUT_CYCLES.
- STALL_COUNTER_WIDTH, 32: width of the statistics counters (optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- isLoadUseHazard  in  1  load-use stall request from the stall unit
- isBranchTaken  in  1  execution stage redirects PC; younger instructions must be flushed
- memoryRequestValid  in  1  memory stage is issuing a data-memory access this cycle
- memoryReady  in  1  data memory completes the access this cycle
- programCounterWriteEnable  out  1  PC may update
- fetchDecodeWriteEnable  out  1  IF/ID register may load
- fetchDecodeFlush  out  1  IF/ID loads a NOP
- decodeExecutionBubble  out  1  ID/EX loads a NOP (control bits zeroed)
- executionMemoryWriteEnable  out  1  ID/EX and EX/MEM registers may load
- memoryWritebackBubble  out  1  MEM/WB loads a NOP
- isMemoryWaiting  out  1  FSM in MEM_WAIT (registered)
- memoryTimeoutError  out  1  sticky; set on timeout, cleared only by reset
- loadUseStallCount  out  STALL_COUNTER_WIDTH  statistics (optional feature)
- memoryStallCount  out  STALL_COUNTER_WIDTH  statistics (optional feature)

Behaviour:
- States: RUN, MEM_WAIT. The state register and counters are registered. Stage control outputs are combinational from the state and the current inputs, so they act in the same cycle.
- Reset (synchronous):
  - Next state RUN; wait counter 0; memoryTimeoutError 0; statistics counters 0.
  - While reset is high: all write enables 0, fetchDecodeFlush 1, decodeExecutionBubble 1, memoryWritebackBubble 1.
- "Advance" output set: all enables 1, flush 0, bubbles 0.
- RUN priority, highest first:
  1. memoryRequestValid && !memoryReady → freeze: PC, IF/ID and EX/MEM enables 0; flush 0; decodeExecutionBubble 0; memoryWritebackBubble 1. Next state MEM_WAIT, wait counter ← 1.
  2. isBranchTaken → PC enable 1, fetchDecodeFlush 1, decodeExecutionBubble 1, executionMemoryWriteEnable 1. Branch overrides a simultaneous load-use hazard.
  3. isLoadUseHazard → PC enable 0, IF/ID enable 0, decodeExecutionBubble 1, executionMemoryWriteEnable 1. This is a one-cycle bubble; if the hazard is still asserted next cycle, another bubble is inserted.
  4. Otherwise → advance.
- MEM_WAIT:
  - memoryReady = 0 and wait counter < MEM_TIMEOUT_CYCLES → freeze outputs as in RUN case 1; counter +1.
  - memoryReady = 1 → outputs follow RUN priorities 2–4 (memory case excluded); next state RUN; counter ← 0.
  - memoryReady = 0 and counter == MEM_TIMEOUT_CYCLES → memoryTimeoutError ← 1; outputs as advance but memoryWritebackBubble 1 (failed load dropped); next state RUN; counter ← 0.
- memoryReady together with memoryRequestValid in RUN counts as a single-cycle access; no wait is entered.
- isMemoryWaiting = (state == MEM_WAIT).
- Reset asserted while in MEM_WAIT returns to RUN next cycle and clears the counter.

Optional Feature:
- Macro: PIPELINE_STALL_STATS_EN.
- Defined:
  - loadUseStallCount increments on each cycle where RUN priority 3 applies.
  - memoryStallCount increments on each freeze cycle.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset high 2 cycles, then low, no requests → enables 0 / flush 1 / bubbles 1 during reset, then advance; isMemoryWaiting 0.
- isLoadUseHazard = 1 for one cycle → that cycle PC enable 0, IF/ID enable 0, decodeExecutionBubble 1; next cycle advance; loadUseStallCount = 1 if PIPELINE_STALL_STATS_EN.
- isBranchTaken = 1 and isLoadUseHazard = 1 together → fetchDecodeFlush 1, decodeExecutionBubble 1, PC enable 1.
- memoryRequestValid = 1, memoryReady low 3 cycles then high → 3 freeze cycles (isMemoryWaiting high for cycles 2–4), advance on the ready cycle; memoryStallCount = 3.
- MEM_TIMEOUT_CYCLES = 4, memoryReady held 0 → timeout cycle shows memoryWritebackBubble 1 and advance; memoryTimeoutError = 1 and stays 1 until reset.
- Reset asserted during MEM_WAIT → state RUN, counter 0, memoryTimeoutError 0 after reset.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Turns hazard indications into per-stage enables, flushes and bubbles, with a
// RUN/MEM_WAIT FSM for multi-cycle data-memory accesses. Optional stats: PIPELINE_STALL_STATS_EN.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT_CYCLES  = 200,
  parameter int WAIT_COUNTER_WIDTH  = 8,
  parameter int STALL_COUNTER_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           isLoadUseHazard,
  input  logic                           isBranchTaken,
  input  logic                           memoryRequestValid,
  input  logic                           memoryReady,
  output logic                           programCounterWriteEnable,
  output logic                           fetchDecodeWriteEnable,
  output logic                           fetchDecodeFlush,
  output logic                           decodeExecutionBubble,
  output logic                           executionMemoryWriteEnable,
  output logic                           memoryWritebackBubble,
  output logic                           isMemoryWaiting,
  output logic                           memoryTimeoutError,
  output logic [STALL_COUNTER_WIDTH-1:0] loadUseStallCount,
  output logic [STALL_COUNTER_WIDTH-1:0] memoryStallCount
);

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  localparam logic [WAIT_COUNTER_WIDTH-1:0] TIMEOUT_VAL = WAIT_COUNTER_WIDTH'(MEM_TIMEOUT_CYCLES);

  state_t                        r_state;
  logic [WAIT_COUNTER_WIDTH-1:0] r_wait_cnt;
  logic                          r_timeout_err;

  logic w_freeze;
  logic w_timeout;
  logic w_resolve;
  logic w_branch;
  logic w_load_use;

  // Classify the cycle: freeze, timeout, or fall through to branch/load-use/advance
  always_comb begin
    w_freeze  = 1'b0;
    w_timeout = 1'b0;
    w_resolve = 1'b0;
    if (r_state == ST_RUN) begin
      if (memoryRequestValid && !memoryReady) w_freeze  = 1'b1;
      else                                    w_resolve = 1'b1;
    end else if (memoryReady) begin
      w_resolve = 1'b1;
    end else if (r_wait_cnt < TIMEOUT_VAL) begin
      w_freeze = 1'b1;
    end else begin
      w_timeout = 1'b1;
    end
  end

  assign w_branch   = w_resolve && isBranchTaken;
  assign w_load_use = w_resolve && !isBranchTaken && isLoadUseHazard;

  always_comb begin
    programCounterWriteEnable  = 1'b1;
    fetchDecodeWriteEnable     = 1'b1;
    fetchDecodeFlush           = 1'b0;
    decodeExecutionBubble      = 1'b0;
    executionMemoryWriteEnable = 1'b1;
    memoryWritebackBubble      = 1'b0;
    if (reset) begin
      programCounterWriteEnable  = 1'b0;
      fetchDecodeWriteEnable     = 1'b0;
      fetchDecodeFlush           = 1'b1;
      decodeExecutionBubble      = 1'b1;
      executionMemoryWriteEnable = 1'b0;
      memoryWritebackBubble      = 1'b1;
    end else if (w_freeze) begin
      programCounterWriteEnable  = 1'b0;
      fetchDecodeWriteEnable     = 1'b0;
      executionMemoryWriteEnable = 1'b0;
      memoryWritebackBubble      = 1'b1;
    end else if (w_timeout) begin
      // abandoned load must not reach writeback
      memoryWritebackBubble = 1'b1;
    end else if (w_branch) begin
      fetchDecodeFlush      = 1'b1;
      decodeExecutionBubble = 1'b1;
    end else if (w_load_use) begin
      programCounterWriteEnable = 1'b0;
      fetchDecodeWriteEnable    = 1'b0;
      decodeExecutionBubble     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_freeze) begin
      r_state    <= ST_MEM_WAIT;
      r_wait_cnt <= (r_state == ST_RUN) ? WAIT_COUNTER_WIDTH'(1) : r_wait_cnt + 1'b1;
    end else begin
      if (w_timeout) r_timeout_err <= 1'b1;
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end
  end

  assign isMemoryWaiting    = (r_state == ST_MEM_WAIT);
  assign memoryTimeoutError = r_timeout_err;

`ifdef PIPELINE_STALL_STATS_EN
  function automatic logic [STALL_COUNTER_WIDTH-1:0] sat_inc(input logic [STALL_COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STALL_COUNTER_WIDTH-1:0] r_load_use_cnt;
  logic [STALL_COUNTER_WIDTH-1:0] r_mem_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_use_cnt  <= '0;
      r_mem_stall_cnt <= '0;
    end else begin
      if (w_load_use) r_load_use_cnt  <= sat_inc(r_load_use_cnt);
      if (w_freeze)   r_mem_stall_cnt <= sat_inc(r_mem_stall_cnt);
    end
  end

  assign loadUseStallCount = r_load_use_cnt;
  assign memoryStallCount  = r_mem_stall_cnt;
`else
  assign loadUseStallCount = '0;
  assign memoryStallCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized + directed bench for pipeline_stall_controller against a behavioural
// model of the stall/flush rules, with a short memory timeout.
module tb_pipeline_stall_controller;

  localparam int T  = 4;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          isLoadUseHazard = 1'b0;
  logic          isBranchTaken = 1'b0;
  logic          memoryRequestValid = 1'b0;
  logic          memoryReady = 1'b0;
  logic          programCounterWriteEnable;
  logic          fetchDecodeWriteEnable;
  logic          fetchDecodeFlush;
  logic          decodeExecutionBubble;
  logic          executionMemoryWriteEnable;
  logic          memoryWritebackBubble;
  logic          isMemoryWaiting;
  logic          memoryTimeoutError;
  logic [SW-1:0] loadUseStallCount;
  logic [SW-1:0] memoryStallCount;

  pipeline_stall_controller #(
    .MEM_TIMEOUT_CYCLES (T),
    .WAIT_COUNTER_WIDTH (8),
    .STALL_COUNTER_WIDTH(SW)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .isLoadUseHazard           (isLoadUseHazard),
    .isBranchTaken             (isBranchTaken),
    .memoryRequestValid        (memoryRequestValid),
    .memoryReady               (memoryReady),
    .programCounterWriteEnable (programCounterWriteEnable),
    .fetchDecodeWriteEnable    (fetchDecodeWriteEnable),
    .fetchDecodeFlush          (fetchDecodeFlush),
    .decodeExecutionBubble     (decodeExecutionBubble),
    .executionMemoryWriteEnable(executionMemoryWriteEnable),
    .memoryWritebackBubble     (memoryWritebackBubble),
    .isMemoryWaiting           (isMemoryWaiting),
    .memoryTimeoutError        (memoryTimeoutError),
    .loadUseStallCount         (loadUseStallCount),
    .memoryStallCount          (memoryStallCount)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: whether an access is outstanding, how long it has been
  // stalling the pipe, and event totals.
  bit          m_pending = 0;
  int          m_stalled = 0;
  bit          m_err = 0;
  longint      m_lu = 0;
  longint      m_ms = 0;
  bit          primed = 0;
  localparam longint SAT = (64'd1 << SW) - 1;

  // {pcWE, ifidWE, flush, idexBubble, exmemWE, memwbBubble}
  localparam logic [5:0] V_RST = 6'b001101;
  localparam logic [5:0] V_FRZ = 6'b000001;
  localparam logic [5:0] V_TMO = 6'b110011;
  localparam logic [5:0] V_BR  = 6'b111110;
  localparam logic [5:0] V_LU  = 6'b000110;
  localparam logic [5:0] V_ADV = 6'b110010;

  task automatic step(input logic rst, input logic lu, input logic br,
                      input logic mrv, input logic mr);
    logic [5:0] exp_v;
    logic [5:0] got_v;
    bit resolve;
    reset = rst; isLoadUseHazard = lu; isBranchTaken = br;
    memoryRequestValid = mrv; memoryReady = mr;
    #2;
    resolve = 0;
    if (rst)                 exp_v = V_RST;
    else if (!m_pending)     begin if (mrv && !mr) exp_v = V_FRZ; else resolve = 1; end
    else if (mr)             resolve = 1;
    else if (m_stalled < T)  exp_v = V_FRZ;
    else                     exp_v = V_TMO;
    if (resolve) exp_v = br ? V_BR : (lu ? V_LU : V_ADV);

    got_v = {programCounterWriteEnable, fetchDecodeWriteEnable, fetchDecodeFlush,
             decodeExecutionBubble, executionMemoryWriteEnable, memoryWritebackBubble};
    chk("stage_ctrl", 64'(got_v), 64'(exp_v));
    if (primed) begin
      chk("mem_waiting", 64'(isMemoryWaiting), 64'(m_pending));
      chk("timeout_err", 64'(memoryTimeoutError), 64'(m_err));
`ifdef PIPELINE_STALL_STATS_EN
      chk("lu_count", 64'(loadUseStallCount), 64'(m_lu));
      chk("mem_count", 64'(memoryStallCount), 64'(m_ms));
`else
      chk("lu_count", 64'(loadUseStallCount), 64'd0);
      chk("mem_count", 64'(memoryStallCount), 64'd0);
`endif
    end

    @(posedge clk);
    primed = 1;
    if (rst) begin
      m_pending = 0; m_stalled = 0; m_err = 0; m_lu = 0; m_ms = 0;
    end else if (exp_v == V_FRZ) begin
      m_stalled = m_pending ? m_stalled + 1 : 1;
      m_pending = 1;
      if (m_ms < SAT) m_ms++;
    end else begin
      if (exp_v == V_TMO) m_err = 1;
      if (exp_v == V_LU && m_lu < SAT) m_lu++;
      m_pending = 0;
      m_stalled = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // reset, then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // single load-use bubble, then back-to-back
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // branch overrides load-use
    step(0, 1, 1, 0, 0);
    // single-cycle access
    step(0, 0, 0, 1, 1);
    // three-cycle wait, ready on the fourth with a load-use pending
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    // timeout, error sticks
    for (int i = 0; i < T + 1; i++) step(0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // reset while waiting
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
           ($urandom % 3) == 0, ($urandom % 4) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
